// File: rtl/grant_scheduler.sv
// Pending-request scheduler: captures request pulses, then serves one requester at a time
// with a registered one-hot grant held until ack. Define GRANT_SCHEDULER_RR_EN for rotating priority.
module grant_scheduler #(
   parameter int N  = 8,
   parameter int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  req,
   input  logic          ack,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_valid,
   output logic [N-1:0]  pending,
   output logic          busy
);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t         state_q;
   logic [N-1:0]   gnt_q;
   logic [IW-1:0]  gnt_idx_q;
   logic           gnt_valid_q;
   logic [N-1:0]   pending_q;
   logic [N-1:0]   pending_d;
   logic [N-1:0]   clr;
   logic           win_hit;
   logic [IW-1:0]  win_idx;
   logic [N-1:0]   win_onehot;

`ifdef GRANT_SCHEDULER_RR_EN
   logic [IW-1:0]  last_q;
   logic [IW-1:0]  rr_pos;
`endif

   // Pending capture: acknowledged grant clears its bit, a coincident request re-sets it
   always_comb begin
      clr = {N{1'b0}};
      if ((state_q == S_GRANT) && ack) begin
         clr = gnt_q;
      end else begin
         clr = {N{1'b0}};
      end
      pending_d = (pending_q & ~clr) | req;
   end

`ifdef GRANT_SCHEDULER_RR_EN
   // Rotating search: start just below the last served index and walk downward with wrap;
   // the loop runs from farthest to nearest so the nearest hit is assigned last
   always_comb begin
      win_hit = 1'b0;
      win_idx = {IW{1'b0}};
      rr_pos  = {IW{1'b0}};
      for (int k = N - 1; k >= 0; k--) begin
         rr_pos = last_q - IW'(1) - IW'(k);
         if (pending_q[rr_pos]) begin
            win_hit = 1'b1;
            win_idx = rr_pos;
         end else begin
            win_hit = win_hit;
         end
      end
   end
`else
   // Fixed priority: the highest set pending bit wins (later iterations override)
   always_comb begin
      win_hit = 1'b0;
      win_idx = {IW{1'b0}};
      for (int i = 0; i < N; i++) begin
         if (pending_q[i]) begin
            win_hit = 1'b1;
            win_idx = IW'(i);
         end else begin
            win_hit = win_hit;
         end
      end
   end
`endif

   assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win_idx;

   // Grant FSM with registered grant outputs and pending register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         gnt_q       <= {N{1'b0}};
         gnt_idx_q   <= {IW{1'b0}};
         gnt_valid_q <= 1'b0;
         pending_q   <= {N{1'b0}};
`ifdef GRANT_SCHEDULER_RR_EN
         last_q      <= {IW{1'b0}};
`endif
      end else begin
         pending_q <= pending_d;
         case (state_q)
            S_IDLE: begin
               if (win_hit) begin
                  gnt_q       <= win_onehot;
                  gnt_idx_q   <= win_idx;
                  gnt_valid_q <= 1'b1;
                  state_q     <= S_GRANT;
               end else begin
                  gnt_q       <= {N{1'b0}};
                  gnt_idx_q   <= {IW{1'b0}};
                  gnt_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            S_GRANT: begin
               if (ack) begin
                  gnt_q       <= {N{1'b0}};
                  gnt_idx_q   <= {IW{1'b0}};
                  gnt_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
`ifdef GRANT_SCHEDULER_RR_EN
                  last_q      <= gnt_idx_q;
`endif
               end else begin
                  gnt_q       <= gnt_q;
                  gnt_idx_q   <= gnt_idx_q;
                  gnt_valid_q <= gnt_valid_q;
                  state_q     <= S_GRANT;
               end
            end
            default: begin
               gnt_q       <= {N{1'b0}};
               gnt_idx_q   <= {IW{1'b0}};
               gnt_valid_q <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = gnt_idx_q;
   assign gnt_valid = gnt_valid_q;
   assign pending   = pending_q;
   assign busy      = gnt_valid_q | (|pending_q);

endmodule

// File: tb/tb_grant_scheduler.sv
// Table-driven scoreboard bench for grant_scheduler; expectations follow GRANT_SCHEDULER_RR_EN.
module tb_grant_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] req = 8'h00;
   logic       ack = 1'b0;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic [7:0] pending;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic       rst;
      logic [7:0] req;
      logic       ack;
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       valid;
      logic [7:0] pend;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];

`ifdef GRANT_SCHEDULER_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   grant_scheduler #(.N(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .ack       (ack),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .pending   (pending),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, input logic [7:0] q, input logic a,
                      input logic [7:0] g, input logic [2:0] i, input logic v,
                      input logic [7:0] p);
      vec_t e;
      e.rst = r; e.req = q; e.ack = a; e.gnt = g; e.idx = i; e.valid = v; e.pend = p;
      vecs.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      vec_t e;
      int   lat;
      // reset held with all requests asserted
      for (int k = 0; k < 3; k++) add(1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
      add(1'b0, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 8'hFF);
      add(1'b0, 8'h00, 1'b0, 8'h80, 3'd7, 1'b1, 8'hFF);
      add(1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 8'h7F);
      add(1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
      add(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
      // fixed-priority drain of 0010_0101
      add(1'b0, 8'h25, 1'b0, 8'h00, 3'd0, 1'b0, 8'h25);
      add(1'b0, 8'h00, 1'b0, 8'h20, 3'd5, 1'b1, 8'h25);
      add(1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 8'h05);
      add(1'b0, 8'h00, 1'b0, 8'h04, 3'd2, 1'b1, 8'h05);
      add(1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 8'h01);
      add(1'b0, 8'h00, 1'b0, 8'h01, 3'd0, 1'b1, 8'h01);
      add(1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00);
      add(1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00);
      // hold without ack, higher request arrives meanwhile
      add(1'b0, 8'h08, 1'b0, 8'h00, 3'd0, 1'b0, 8'h08);
      for (int k = 0; k < 5; k++) add(1'b0, 8'h00, 1'b0, 8'h08, 3'd3, 1'b1, 8'h08);
      add(1'b0, 8'h80, 1'b0, 8'h08, 3'd3, 1'b1, 8'h88);
      add(1'b0, 8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 8'h88);
      for (int k = 0; k < 3; k++) add(1'b0, 8'h00, 1'b0, 8'h08, 3'd3, 1'b1, 8'h88);
      add(1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 8'h80);
      add(1'b0, 8'h00, 1'b0, 8'h80, 3'd7, 1'b1, 8'h80);
      add(1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00);
      // set wins over ack clear
      add(1'b0, 8'h08, 1'b0, 8'h00, 3'd0, 1'b0, 8'h08);
      add(1'b0, 8'h00, 1'b0, 8'h08, 3'd3, 1'b1, 8'h08);
      add(1'b0, 8'h08, 1'b1, 8'h00, 3'd0, 1'b0, 8'h08);
      add(1'b0, 8'h00, 1'b0, 8'h08, 3'd3, 1'b1, 8'h08);
      add(1'b0, 8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 8'h00);
      // reset mid-grant with gnt=40, pending=C1
      add(1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
      add(1'b0, 8'h41, 1'b0, 8'h00, 3'd0, 1'b0, 8'h41);
      add(1'b0, 8'h80, 1'b0, 8'h40, 3'd6, 1'b1, 8'hC1);
      add(1'b0, 8'h00, 1'b0, 8'h40, 3'd6, 1'b1, 8'hC1);
      add(1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
      for (int k = 0; k < 2; k++) add(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00);
      // continuous 81 request: alternation only with rotating priority
      add(1'b0, 8'h81, 1'b0, 8'h00, 3'd0, 1'b0, 8'h81);
      add(1'b0, 8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 8'h81);
      for (int k = 0; k < 3; k++) begin
         add(1'b0, 8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 8'h81);
         if (RR && (k % 2 == 0)) add(1'b0, 8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 8'h81);
         else                    add(1'b0, 8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 8'h81);
      end
      add(1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 8'h00);

      for (int n = 0; n < vecs.size(); n++) begin
         @(negedge clk);
         reset = vecs[n].rst;
         req   = vecs[n].req;
         ack   = vecs[n].ack;
         exp_q.push_back(vecs[n]);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         chk($sformatf("v%0d gnt", n),       {24'h0, gnt},       {24'h0, e.gnt});
         chk($sformatf("v%0d gnt_idx", n),   {29'h0, gnt_idx},   {29'h0, e.idx});
         chk($sformatf("v%0d gnt_valid", n), {31'h0, gnt_valid}, {31'h0, e.valid});
         chk($sformatf("v%0d pending", n),   {24'h0, pending},   {24'h0, e.pend});
         chk($sformatf("v%0d busy", n),      {31'h0, busy},
             {31'h0, (e.valid | (|e.pend))});
      end

      // request-to-grant latency from idle, bounded wait
      @(negedge clk);
      reset = 1'b0; req = 8'h02; ack = 1'b0;
      @(posedge clk); #1;
      lat = 1;
      @(negedge clk);
      req = 8'h00;
      while (!gnt_valid && lat < 6) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, 32'd2);
      chk("latency gnt", {24'h0, gnt}, 32'h02);
      @(negedge clk);
      ack = 1'b1;
      @(posedge clk); #1;
      chk("final busy", {31'h0, busy}, 32'h0);
      @(negedge clk);
      ack = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
